// File: rtl/controlador_estados.sv
// controlador_estados: pet behaviour FSM that drives the estado bus.
// Optional age counter is enabled with CONTROLADOR_ESTADOS_IDADE_EN.
module controlador_estados #(
  parameter int TICK_BITS   = 23,
  parameter int DUR_ACAO    = 20,
  parameter int MORTE_TICKS = 10,
  parameter int INTRO_TICKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic        btn_dormir,
  input  logic        btn_comer,
  input  logic        btn_aula,
  input  logic [7:0]  fome,
  input  logic [7:0]  felicidade,
  input  logic [7:0]  sono,
  output logic [4:0]  estado,
  output logic        morreu,
  output logic [15:0] idade
);

  typedef enum logic [4:0] {
    INTRO      = 5'b00000,
    IDLE       = 5'b00001,
    DORMINDO   = 5'b00010,
    COMENDO    = 5'b00100,
    DANDO_AULA = 5'b01000,
    MORTO      = 5'b10000
  } state_e;

  localparam logic [7:0] DUR_L   = 8'(DUR_ACAO);
  localparam logic [7:0] MORTE_L = 8'(MORTE_TICKS);
  localparam logic [7:0] INTRO_L = 8'(INTRO_TICKS);
  localparam logic [7:0] FULL_L  = 8'd100;
  localparam logic [TICK_BITS-1:0] TICK_ONE = TICK_BITS'(1);

  state_e               state_q, state_d;
  logic [TICK_BITS-1:0] tick_q;
  logic [7:0]           dwell_q, dwell_d;
  logic [7:0]           timer_q, timer_d;
  logic [7:0]           zero_q, zero_d;
  logic                 morreu_q, morreu_d;

  logic tick;
  logic any_zero;
  logic watch;
  logic death;
  logic attr_full;
  logic fim;

  assign tick = (tick_q == '0);

  assign any_zero = (fome == 8'd0)
                  | (sono == 8'd0)
                  | (felicidade == 8'd0);

  assign watch = (state_q != INTRO)
              && (state_q != MORTO);

  // Attribute that the current action raises has topped out.
  always_comb begin
    attr_full = 1'b0;
    unique case (state_q)
      DORMINDO:   attr_full = (sono >= FULL_L);
      COMENDO:    attr_full = (fome >= FULL_L);
      DANDO_AULA: attr_full = (felicidade >= FULL_L);
      default:    attr_full = 1'b0;
    endcase
  end

  assign fim = btn_start
             | attr_full
             | (tick && (timer_q == 8'd1));

  always_comb begin
    zero_d = zero_q;
    death  = 1'b0;
    if (watch && tick) begin
      if (!any_zero) begin
        zero_d = '0;
      end else if (zero_q < MORTE_L) begin
        zero_d = zero_q + 8'd1;
      end
      death = any_zero && (zero_d >= MORTE_L);
    end
    if ((state_q == MORTO) && btn_start) begin
      zero_d = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    timer_d = timer_q;
    unique case (state_q)
      INTRO: begin
        if (tick && (dwell_q < INTRO_L)) begin
          dwell_d = dwell_q + 8'd1;
        end
        if (btn_start && (dwell_q >= INTRO_L)) begin
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (death) begin
          state_d = MORTO;
        end else if (btn_dormir) begin
          state_d = DORMINDO;
          timer_d = DUR_L;
        end else if (btn_comer) begin
          state_d = COMENDO;
          timer_d = DUR_L;
        end else if (btn_aula) begin
          state_d = DANDO_AULA;
          timer_d = DUR_L;
        end
      end
      DORMINDO, COMENDO, DANDO_AULA: begin
        if (tick && (timer_q != 8'd0)) begin
          timer_d = timer_q - 8'd1;
        end
        if (death) begin
          state_d = MORTO;
          timer_d = '0;
        end else if (fim) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      MORTO: begin
        if (btn_start) begin
          state_d = INTRO;
          dwell_d = '0;
        end
      end
      default: begin
        state_d = INTRO;
        dwell_d = '0;
        timer_d = '0;
      end
    endcase
  end

  assign morreu_d = (state_d == MORTO)
                 && (state_q != MORTO);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= INTRO;
      tick_q   <= '0;
      dwell_q  <= '0;
      timer_q  <= '0;
      zero_q   <= '0;
      morreu_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tick_q   <= tick_q + TICK_ONE;
      dwell_q  <= dwell_d;
      timer_q  <= timer_d;
      zero_q   <= zero_d;
      morreu_q <= morreu_d;
    end
  end

  assign estado = state_q;
  assign morreu = morreu_q;

`ifdef CONTROLADOR_ESTADOS_IDADE_EN
  logic [15:0] idade_q, idade_d;

  always_comb begin
    idade_d = idade_q;
    if (state_d == INTRO) begin
      idade_d = '0;
    end else if (tick && watch
                 && (idade_q != 16'hFFFF)) begin
      idade_d = idade_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idade_q <= '0;
    end else begin
      idade_q <= idade_d;
    end
  end

  assign idade = idade_q;
`else
  assign idade = 16'd0;
`endif

endmodule

// File: doc/controlador_estados.md
# controlador_estados

Behavioural state machine that drives the 5-bit `estado` bus consumed by the attribute controller. It takes debounced button pulses plus the current hunger, happiness and sleep attributes, and decides which activity the pet is in. It also detects starvation or neglect and forces the MORTO state. It sits between the button/debounce front-end and the attribute controller, and closes the loop on `fome`, `felicidade` and `sono`.

## Interface
- `TICK_BITS`, 23: width of the free-running tick counter; one tick every 2^TICK_BITS cycles, the same cadence as attribute updates.
- `DUR_ACAO`, 20: length of an action (DORMINDO/COMENDO/DANDO_AULA) in ticks; range 1..255.
- `MORTE_TICKS`, 10: consecutive ticks with any attribute at 0 before death; range 1..255.
- `INTRO_TICKS`, 2: minimum ticks spent in INTRO before `btn_start` is accepted; range 1..255.
- `clk` input 1: system clock; the only clock.
- `rst` input 1: reset, synchronous and active-high.
- `btn_start` input 1: one-cycle pulse.
- `btn_dormir` input 1: one-cycle pulse.
- `btn_comer` input 1: one-cycle pulse.
- `btn_aula` input 1: one-cycle pulse.
- `fome` input 8: hunger attribute, 0..100.
- `felicidade` input 8: happiness attribute, 0..100.
- `sono` input 8: sleep attribute, 0..100.
- `estado` output 5: current state; registered.
- `morreu` output 1: one-cycle pulse on entry to MORTO.
- `idade` output 16: age in ticks (see Configuration).

## Operation
- State encodings:
  - INTRO = 5'b00000
  - IDLE = 5'b00001
  - DORMINDO = 5'b00010
  - COMENDO = 5'b00100
  - DANDO_AULA = 5'b01000
  - MORTO = 5'b10000
  - No other value is ever driven.
- Tick: internal counter `TICK_BITS` wide, reset to 0, increments every cycle and wraps. `tick` = (counter == 0).
- INTRO:
  - Dwell counter increments on each tick, saturating at `INTRO_TICKS`.
  - `btn_start` is ignored until the dwell counter reaches `INTRO_TICKS`. This guarantees the attribute controller sees INTRO on at least one of its ticks and reloads its initial values.
  - After that, `btn_start` -> IDLE.
- IDLE:
  - Button priority is `btn_dormir` > `btn_comer` > `btn_aula`; the selected button moves to DORMINDO / COMENDO / DANDO_AULA.
  - On entry to any action state, the action timer is loaded with `DUR_ACAO`.
  - `btn_start` is ignored.
- Action states:
  - The timer decrements on each tick. On the tick where it goes 1 -> 0, the state returns to IDLE.
  - Early exit to IDLE in any cycle where the raised attribute is >= 100: `sono` for DORMINDO, `fome` for COMENDO, `felicidade` for DANDO_AULA.
  - `btn_start` cancels the action -> IDLE.
  - Other buttons are ignored.
- Death watch:
  - Active in IDLE and the action states.
  - On each tick: if `fome`==0 or `sono`==0 or `felicidade`==0, the zero counter increments; otherwise it clears.
  - When the zero counter reaches `MORTE_TICKS`, the state becomes MORTO and `morreu` pulses.
  - The zero counter clears on entering INTRO.
- MORTO: `btn_start` -> INTRO, which clears the dwell counter. All other inputs are ignored.
- Priority within one cycle: death > action end/early exit/cancel > button start.
- All counters saturate; none wraps except the tick counter.

## Timing
- Reset values:
  - `estado` = INTRO
  - `morreu` = 0
  - `idade` = 0
  - tick counter, dwell, action timer and zero counter = 0
- The first `tick` occurs in the first cycle after `rst` deasserts.
- Latency:
  - An input event in cycle N is reflected on `estado` at N+1.
  - `morreu` is high in the same cycle `estado` first shows MORTO, for exactly one cycle.
- Attribute inputs are sampled every cycle for early exit, and only on `tick` for death.
- A button pulse coincident with a death tick: MORTO wins and the button is dropped.
- A button pulse during an action is not queued.
- `rst` asserted in any state: INTRO on the next cycle, with all counters cleared. A partially elapsed action is discarded.

## Configuration
- `CONTROLADOR_ESTADOS_IDADE_EN`:
  - Defined: `idade` increments on each tick while `estado` is IDLE or an action state, saturates at 16'hFFFF, holds in MORTO, and clears on INTRO entry and on reset.
  - Undefined: `idade` is tied to 16'd0 and no age counter is synthesised.

## Test plan
All scenarios use `TICK_BITS`=4 (tick every 16 cycles), `DUR_ACAO`=3, `MORTE_TICKS`=2, `INTRO_TICKS`=2.
- **Intro dwell:** reset, pulse `btn_start` at cycle 5 -> `estado` stays 00000; pulse again after the 2nd tick (cycle 17) -> `estado`=00001 at cycle 18.
- **Button priority and duration:** in IDLE, pulse `btn_dormir` and `btn_aula` in the same cycle -> 00010 next cycle. Hold `sono`=50 -> IDLE after the third subsequent tick.
- **Early exit:** in COMENDO, set `fome`=100 at cycle K -> `estado`=00001 at K+1, before the timer expires.
- **Death:** in IDLE, set `felicidade`=0 across 2 ticks -> `estado`=10000 and `morreu`=1 for exactly one cycle. A simultaneous `btn_comer` on the death tick is ignored.
- **Zero-counter clear:** `fome`=0 for 1 tick, then 5 for the next tick, then 0 for 1 tick -> no death.
- **Recovery and reset:**
  - In MORTO, `btn_start` -> 00000; `idade`=0 with `CONTROLADOR_ESTADOS_IDADE_EN` defined.
  - `rst` mid-DANDO_AULA -> 00000 next cycle.
  - Without the macro, `idade` is 0 throughout.
